hcsr04_medidor_multi: RTL

Parametrised ultrasonic ranging controller for HC-SR04-class sensors, successor to the single-sensor trena datapath. It drives NUM_CH sensors strictly one at a time in round-robin sweeps, so their echoes cannot crosstalk. For each channel it generates the trigger pulse, times the echo, and converts the echo width to rounded centimetres in BCD. It also flags missing or over-range echoes, and supports single-shot or continuous sweeping. It sits between the sensor pins and the display/serial-transmit logic.

---
 rtl/hcsr04_medidor_multi.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/hcsr04_medidor_multi.sv
// Round-robin HC-SR04 ranging controller: triggers each sensor in turn, times its echo
// and stores the distance as rounded BCD centimetres, with per-channel error flags.
module hcsr04_medidor_multi #(
    parameter int NUM_CH       = 2,
    parameter int DIGITS       = 3,
    parameter int CLK_PER_US   = 50,
    parameter int TRIGGER_US   = 10,
    parameter int TICKS_PER_CM = 2941,
    parameter int MAX_CM       = 400,
    parameter int ECHO_WAIT_US = 2000,
    parameter int GAP_US       = 100,
    localparam int CW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       mensurar,
    input  logic                       continuo,
    input  logic [NUM_CH-1:0]          echo,
    output logic [NUM_CH-1:0]          trigger,
    output logic [NUM_CH*DIGITS*4-1:0] medida,
    output logic [NUM_CH-1:0]          erro,
    output logic [CW-1:0]              canal,
    output logic                       ocupado,
    output logic                       pronto,
    output logic [3:0]                 db_estado
);

    localparam int DW = DIGITS * 4;
    localparam int TW = $clog2(TICKS_PER_CM + 1);

    localparam logic [31:0]    TRIG_LAST  = 32'(TRIGGER_US * CLK_PER_US - 1);
    localparam logic [31:0]    WAIT_LAST  = 32'(ECHO_WAIT_US * CLK_PER_US - 1);
    localparam logic [31:0]    GAP_LAST   = 32'(GAP_US * CLK_PER_US - 1);
    localparam logic [TW-1:0]  TICK_LAST  = TW'(TICKS_PER_CM - 1);
    localparam logic [TW-1:0]  TICK_HALF  = TW'(TICKS_PER_CM / 2);
    localparam logic [CW-1:0]  CANAL_LAST = CW'(NUM_CH - 1);

    function automatic logic [DW-1:0] to_bcd(input int value);
        logic [DW-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [DW-1:0] MAX_BCD = to_bcd(MAX_CM);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        TRIGGER   = 4'd1,
        WAIT_ECHO = 4'd2,
        MEASURE   = 4'd3,
        STORE     = 4'd4,
        GAP       = 4'd5,
        DONE      = 4'd6
    } state_t;

    state_t              state, state_next;
    logic [CW-1:0]       canal_next;
    logic [31:0]         timer;
    logic [TW-1:0]       tick;
    logic [DW-1:0]       cm;
    logic [DW-1:0]       cm_inc;
    logic                timeout_flag;
    logic                over_flag;
    logic [NUM_CH-1:0]   echo_s1, echo_s2, echo_d;
    logic                mens_d;
    logic                mens_rise;
    logic                echo_sel, echo_sel_d, echo_rise;

    // mensurar is a start strobe (rising edge, honoured only in IDLE); pronto is the
    // matching one-cycle completion strobe. There is no backpressure on either side.
    assign mens_rise  = mensurar & ~mens_d;
    assign echo_sel   = echo_s2[canal];
    assign echo_sel_d = echo_d[canal];
    assign echo_rise  = echo_sel & ~echo_sel_d;
    assign cm_inc     = bcd_inc(cm);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            canal <= '0;
        end else begin
            state <= state_next;
            canal <= canal_next;
        end
    end

    always_comb begin
        state_next = state;
        canal_next = canal;
        case (state)
            IDLE: begin
                if (mens_rise) begin
                    state_next = TRIGGER;
                    canal_next = '0;
                end
            end
            TRIGGER: begin
                if (timer == TRIG_LAST) state_next = WAIT_ECHO;
            end
            WAIT_ECHO: begin
                if (echo_rise)              state_next = MEASURE;
                else if (timer == WAIT_LAST) state_next = STORE;
            end
            MEASURE: begin
                // Over-range leaves without waiting for the echo to fall.
                if (!echo_sel)                                   state_next = STORE;
                else if (tick == TICK_LAST && cm_inc == MAX_BCD) state_next = STORE;
            end
            STORE: state_next = GAP;
            GAP: begin
                if (timer == GAP_LAST) begin
                    if (canal == CANAL_LAST) begin
                        state_next = DONE;
                    end else begin
                        state_next = TRIGGER;
                        canal_next = canal + CW'(1);
                    end
                end
            end
            DONE: begin
                if (continuo) begin
                    state_next = TRIGGER;
                    canal_next = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            echo_s1      <= '0;
            echo_s2      <= '0;
            echo_d       <= '0;
            mens_d       <= 1'b0;
            timer        <= '0;
            tick         <= '0;
            cm           <= '0;
            timeout_flag <= 1'b0;
            over_flag    <= 1'b0;
            trigger      <= '0;
            medida       <= '0;
            erro         <= '0;
            pronto       <= 1'b0;
            ocupado      <= 1'b0;
            db_estado    <= 4'd0;
        end else begin
            echo_s1   <= echo;
            echo_s2   <= echo_s1;
            echo_d    <= echo_s2;
            mens_d    <= mensurar;
            timer     <= (state_next != state) ? 32'd0 : timer + 32'd1;
            pronto    <= (state == DONE);
            ocupado   <= (state_next != IDLE);
            db_estado <= state_next;

            trigger <= '0;
            if (state == TRIGGER) trigger[canal] <= 1'b1;

            case (state)
                TRIGGER: begin
                    timeout_flag <= 1'b0;
                    over_flag    <= 1'b0;
                end
                WAIT_ECHO: begin
                    if (echo_rise) begin
                        tick <= '0;
                        cm   <= '0;
                    end else if (timer == WAIT_LAST) begin
                        timeout_flag <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (!echo_sel) begin
                        // Round to nearest: a remainder of half a centimetre or more counts.
                        if (tick >= TICK_HALF) cm <= cm_inc;
                    end else if (tick == TICK_LAST) begin
                        tick <= '0;
                        cm   <= cm_inc;
                        if (cm_inc == MAX_BCD) over_flag <= 1'b1;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                STORE: begin
                    if (!timeout_flag) medida[int'(canal)*DW +: DW] <= cm;
                    erro[canal] <= timeout_flag | over_flag;
                end
                default: ;
            endcase
        end
    end

endmodule
